// File: rtl/comparator_2bit_df_if.sv
// Operand/result bundle for comparator_2bit_df.
// The master drives the operands; the slave (the comparator) returns flags, max, diff and counters.
interface comparator_2bit_df_if;
  logic [1:0] A;
  logic [1:0] B;
  logic       in_valid;
  logic       stat_clr;
  logic       A_gt_B;
  logic       A_eq_B;
  logic       A_lt_B;
  logic       out_valid;
  logic [1:0] max_val;
  logic [1:0] abs_diff;
  logic [7:0] gt_cnt;
  logic [7:0] eq_cnt;
  logic [7:0] lt_cnt;

  modport master (
    output A, B, in_valid, stat_clr,
    input  A_gt_B, A_eq_B, A_lt_B, out_valid, max_val, abs_diff, gt_cnt, eq_cnt, lt_cnt
  );

  modport slave (
    input  A, B, in_valid, stat_clr,
    output A_gt_B, A_eq_B, A_lt_B, out_valid, max_val, abs_diff, gt_cnt, eq_cnt, lt_cnt
  );
endinterface

// File: rtl/comparator_2bit_df.sv
// Registered 2-bit unsigned comparator with max/|diff| outputs and optional saturating counters.
// Counters exist only when COMPARATOR_2BIT_DF_STATS_EN is defined; otherwise they read 0.
module comparator_2bit_df (
  input logic                  clk,
  input logic                  rst_n,
  comparator_2bit_df_if.slave  bus
);
  logic       w_gt;
  logic       w_eq;
  logic       w_lt;
  logic [1:0] w_max;
  logic [1:0] w_diff;

  logic       r_gt;
  logic       r_eq;
  logic       r_lt;
  logic       r_out_valid;
  logic [1:0] r_max;
  logic [1:0] r_diff;

  assign w_gt   = (bus.A > bus.B);
  assign w_eq   = (bus.A == bus.B);
  assign w_lt   = (bus.A < bus.B);
  assign w_max  = w_lt ? bus.B : bus.A;
  // Subtract smaller from larger so the 2-bit result never wraps.
  assign w_diff = w_lt ? (bus.B - bus.A) : (bus.A - bus.B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt        <= 1'b0;
      r_eq        <= 1'b1;
      r_lt        <= 1'b0;
      r_out_valid <= 1'b0;
      r_max       <= 2'd0;
      r_diff      <= 2'd0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_gt   <= w_gt;
        r_eq   <= w_eq;
        r_lt   <= w_lt;
        r_max  <= w_max;
        r_diff <= w_diff;
      end
    end
  end

  assign bus.A_gt_B    = r_gt;
  assign bus.A_eq_B    = r_eq;
  assign bus.A_lt_B    = r_lt;
  assign bus.out_valid = r_out_valid;
  assign bus.max_val   = r_max;
  assign bus.abs_diff  = r_diff;

`ifdef COMPARATOR_2BIT_DF_STATS_EN
  logic [2:0] w_hit;
  assign w_hit = {w_gt, w_eq, w_lt};

  // Index 0 = lt, 1 = eq, 2 = gt; clear wins over a same-edge increment.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [7:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= 8'd0;
        end else if (bus.stat_clr) begin
          r_cnt <= 8'd0;
        end else if (bus.in_valid && w_hit[gi] && (r_cnt != 8'hFF)) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  endgenerate

  assign bus.lt_cnt = g_cnt[0].r_cnt;
  assign bus.eq_cnt = g_cnt[1].r_cnt;
  assign bus.gt_cnt = g_cnt[2].r_cnt;
`else
  logic w_unused_stat_clr;
  assign w_unused_stat_clr = bus.stat_clr;
  assign bus.gt_cnt = 8'd0;
  assign bus.eq_cnt = 8'd0;
  assign bus.lt_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_comparator_2bit_df.sv
// Directed testbench for comparator_2bit_df: vector table, exhaustive sweep, saturation and async reset.
// Counter expectations follow COMPARATOR_2BIT_DF_STATS_EN as defined for the build.
module tb_comparator_2bit_df;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  comparator_2bit_df_if bus ();

  comparator_2bit_df dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       v;
    logic [7:0] exp;   // {gt, eq, lt, out_valid, max[1:0], diff[1:0]}
  } vec_t;

  vec_t vecs [7];

  // Expected counter values, maintained as the stimulus is applied.
  int e_gt;
  int e_eq;
  int e_lt;

  function automatic logic [7:0] outs();
    return {bus.A_gt_B, bus.A_eq_B, bus.A_lt_B, bus.out_valid, bus.max_val, bus.abs_diff};
  endfunction

  task automatic check_out(input string name, input logic [7:0] exp);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL %s: got gt/eq/lt/ov/max/diff=%b required %b", name, outs(), exp);
    end
  endtask

  task automatic check_cnt(input string name);
    n_tests++;
    if (bus.gt_cnt !== 8'(e_gt) || bus.eq_cnt !== 8'(e_eq) || bus.lt_cnt !== 8'(e_lt)) begin
      n_fail++;
      $display("FAIL %s: got cnt gt/eq/lt=%0d/%0d/%0d required %0d/%0d/%0d",
               name, bus.gt_cnt, bus.eq_cnt, bus.lt_cnt, e_gt, e_eq, e_lt);
    end
  endtask

  // Apply one cycle of stimulus, wait past the capturing edge, and advance the counter model.
  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic v, input logic clr);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
    bus.stat_clr = clr;
    @(posedge clk);
    #1;
`ifdef COMPARATOR_2BIT_DF_STATS_EN
    if (clr) begin
      e_gt = 0; e_eq = 0; e_lt = 0;
    end else if (v) begin
      if (a > b && e_gt < 255) e_gt++;
      if (a == b && e_eq < 255) e_eq++;
      if (a < b && e_lt < 255) e_lt++;
    end
`endif
  endtask

  initial begin
    logic [7:0] exp;
    n_tests = 0;
    n_fail  = 0;
    e_gt = 0; e_eq = 0; e_lt = 0;

    vecs[0] = '{2'd0, 2'd0, 1'b1, 8'b0101_00_00};
    vecs[1] = '{2'd1, 2'd0, 1'b1, 8'b1001_01_01};
    vecs[2] = '{2'd1, 2'd2, 1'b1, 8'b0011_10_01};
    vecs[3] = '{2'd2, 2'd1, 1'b1, 8'b1001_10_01};
    vecs[4] = '{2'd3, 2'd3, 1'b1, 8'b0101_11_00};
    vecs[5] = '{2'd0, 2'd3, 1'b0, 8'b0100_11_00};
    vecs[6] = '{2'd2, 2'd0, 1'b0, 8'b0100_11_00};

    bus.A = 2'd0; bus.B = 2'd0; bus.in_valid = 1'b0; bus.stat_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 8'b0100_00_00);
    check_cnt("reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive table entries go in on consecutive edges (back-to-back valid).
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].v, 1'b0);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end
    check_cnt("cnt_after_table");

    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        drive(2'(a), 2'(b), 1'b1, 1'b0);
        exp[7]   = (a > b);
        exp[6]   = (a == b);
        exp[5]   = (a < b);
        exp[4]   = 1'b1;
        exp[3:2] = 2'((a > b) ? a : b);
        exp[1:0] = 2'((a > b) ? a - b : b - a);
        check_out($sformatf("sweep_a%0d_b%0d", a, b), exp);
      end
    end
    check_cnt("cnt_after_sweep");

    for (int i = 0; i < 300; i++) drive(2'd3, 2'd0, 1'b1, 1'b0);
    check_out("sat_flags", 8'b1001_11_11);
    check_cnt("cnt_saturated");

    // Clear with a simultaneous valid sample: counters zero, flags still updated.
    drive(2'd0, 2'd2, 1'b1, 1'b1);
    check_out("clr_flags", 8'b0011_10_10);
    check_cnt("cnt_cleared");

    drive(2'd2, 2'd2, 1'b1, 1'b0);
    check_out("post_clr_flags", 8'b0101_10_00);
    check_cnt("cnt_post_clr");

    // Async reset between edges while a sample is being presented.
    @(negedge clk);
    bus.A = 2'd3; bus.B = 2'd1; bus.in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e_gt = 0; e_eq = 0; e_lt = 0;
    check_out("async_reset", 8'b0100_00_00);
    check_cnt("async_reset_cnt");
    @(posedge clk);
    #1;
    check_out("reset_held", 8'b0100_00_00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd1, 2'd2, 1'b1, 1'b0);
    check_out("first_after_reset", 8'b0011_10_01);
    check_cnt("cnt_first_after_reset");

    drive(2'd1, 2'd2, 1'b0, 1'b0);
    check_out("idle_after_reset", 8'b0010_10_01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
